// File: rtl/led_pkg.sv
// Shared constants and encodings for the LED counter bus and its consumers.
package led_pkg;

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned N_LED    = 1 << CNT_W;
    localparam int unsigned PWM_W    = 4;
    localparam int unsigned FADE_DIV = 16;
    localparam int unsigned ERR_W    = 8;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

    typedef enum logic {
        FADE_IDLE   = 1'b0,
        FADE_ACTIVE = 1'b1
    } fade_state_t;

endpackage

// File: rtl/led_count_monitor_if.sv
// Bus between the LED counter side (master) and the count monitor (slave).
interface led_count_monitor_if #(
    parameter int unsigned CNT_W = led_pkg::CNT_W,
    parameter int unsigned ERR_W = led_pkg::ERR_W
);

    localparam int unsigned N_LED = 1 << CNT_W;

    logic [CNT_W-1:0] count_in;
    logic             mode;
    logic             err_clr;
    logic [N_LED-1:0] led;
    logic             step_ok;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;
    logic             fading;

    modport master (
        output count_in, mode, err_clr,
        input  led, step_ok, seq_err, err_cnt, fading
    );

    modport slave (
        input  count_in, mode, err_clr,
        output led, step_ok, seq_err, err_cnt, fading
    );

endinterface

// File: rtl/led_pwm.sv
// Free-running PWM counter with a brightness compare; reusable LED dimmer.
module led_pwm #(
    parameter int unsigned PWM_W = led_pkg::PWM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] bright,
    output logic             pwm_on_c
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    assign pwm_on_c = (pwm_cnt < bright);

endmodule

// File: rtl/led_count_monitor.sv
// Consumer of the LED counter bus: bar display with PWM afterglow on the vacated LED,
// +1 step checker and saturating sequence-error counter.
module led_count_monitor #(
    parameter int unsigned CNT_W    = led_pkg::CNT_W,
    parameter int unsigned PWM_W    = led_pkg::PWM_W,
    parameter int unsigned FADE_DIV = led_pkg::FADE_DIV,
    parameter int unsigned ERR_W    = led_pkg::ERR_W
) (
    input  logic                clk,
    input  logic                reset,
    led_count_monitor_if.slave  bus
);

    import led_pkg::*;

    localparam int unsigned N_LED = 1 << CNT_W;
    localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_W-1:0] BRIGHT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] prev_q;
    logic [N_LED-1:0] led_q;
    logic             step_ok_q;
    logic             seq_err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             fading_q;

    fade_state_t      state,     state_d;
    logic [CNT_W-1:0] ghost_idx, ghost_idx_d;
    logic [PWM_W-1:0] bright,    bright_d;
    logic [DIV_W-1:0] presc,     presc_d;

    logic             change_c;
    logic             legal_c;
    logic             pwm_on_c;
    logic [N_LED-1:0] bar_c;
    logic [N_LED-1:0] ghost_c;
    logic [ERR_W-1:0] err_cnt_d;

    led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk      (clk),
        .reset    (reset),
        .bright   (bright),
        .pwm_on_c (pwm_on_c)
    );

    // Step checker: a change is legal only as a +1 step, wrapping at the top.
    assign change_c = (cnt_q != prev_q);
    assign legal_c  = (cnt_q == prev_q + CNT_W'(1));

    always_comb begin
        bar_c = '0;
        for (int unsigned i = 0; i < N_LED; i++) begin
            if (bus.mode == MODE_THERMO) begin
                bar_c[i] = (CNT_W'(i) <= cnt_q);
            end else begin
                bar_c[i] = (CNT_W'(i) == cnt_q);
            end
        end
    end

    always_comb begin
        ghost_c = '0;
        if (state == FADE_ACTIVE && pwm_on_c) begin
            ghost_c[ghost_idx] = 1'b1;
        end
    end

    // Afterglow FSM: any change (re)starts a full-brightness fade of the old position.
    always_comb begin
        state_d     = state;
        ghost_idx_d = ghost_idx;
        bright_d    = bright;
        presc_d     = presc;
        case (state)
            FADE_IDLE: begin
                if (change_c) begin
                    state_d     = FADE_ACTIVE;
                    ghost_idx_d = prev_q;
                    bright_d    = BRIGHT_MAX;
                    presc_d     = '0;
                end
            end
            FADE_ACTIVE: begin
                if (change_c) begin
                    ghost_idx_d = prev_q;
                    bright_d    = BRIGHT_MAX;
                    presc_d     = '0;
                end else if (presc == DIV_LAST) begin
                    presc_d  = '0;
                    bright_d = bright - PWM_W'(1);
                    if (bright == PWM_W'(1)) begin
                        state_d = FADE_IDLE;
                    end
                end else begin
                    presc_d = presc + DIV_W'(1);
                end
            end
            default: state_d = FADE_IDLE;
        endcase
    end

    // Clear takes priority over hold but still counts an error pulse in the same cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = seq_err_q ? ERR_W'(1) : '0;
        end else if (seq_err_q && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FADE_IDLE;
            ghost_idx <= '0;
            bright    <= '0;
            presc     <= '0;
        end else begin
            state     <= state_d;
            ghost_idx <= ghost_idx_d;
            bright    <= bright_d;
            presc     <= presc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            prev_q    <= '0;
            led_q     <= '0;
            step_ok_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
            fading_q  <= 1'b0;
        end else begin
            cnt_q     <= bus.count_in;
            prev_q    <= cnt_q;
            led_q     <= bar_c | ghost_c;
            step_ok_q <= change_c & legal_c;
            seq_err_q <= change_c & ~legal_c;
            err_cnt_q <= err_cnt_d;
            fading_q  <= (state_d == FADE_ACTIVE);
        end
    end

    assign bus.led     = led_q;
    assign bus.step_ok = step_ok_q;
    assign bus.seq_err = seq_err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.fading  = fading_q;

endmodule

// File: tb/tb_led_count_monitor.sv
// Scoreboard bench for led_count_monitor: step/error pulses, bar decode, afterglow, error counter.
module tb_led_count_monitor;

    localparam int unsigned FADE_DIV_TB = 2;
    localparam int          FADE_LEN    = 15 * FADE_DIV_TB;

    typedef struct {
        logic       step_ok;
        logic       seq_err;
        logic [7:0] bar;
    } exp_t;

    logic clk;
    logic reset;

    led_count_monitor_if #(.CNT_W(3), .ERR_W(8)) bus ();

    led_count_monitor #(
        .CNT_W    (3),
        .PWM_W    (4),
        .FADE_DIV (FADE_DIV_TB),
        .ERR_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    logic [2:0] model_prev;
    logic       model_mode;
    int         model_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bar_model(input logic [2:0] v, input logic m);
        logic [8:0] t;
        if (m) begin
            t = (9'd2 << v) - 9'd1;
            return t[7:0];
        end
        return 8'd1 << v;
    endfunction

    // Drive a new count and record what the checker must report for it.
    task automatic drive_and_push(input logic [2:0] v);
        exp_t       e;
        logic [2:0] nxt;
        nxt       = model_prev + 3'd1;
        e.step_ok = (v != model_prev) && (v == nxt);
        e.seq_err = (v != model_prev) && (v != nxt);
        e.bar     = bar_model(v, model_mode);
        if (e.seq_err && model_err < 255) model_err++;
        model_prev   = v;
        bus.count_in = v;
        exp_q.push_back(e);
    endtask

    task automatic apply_count(input logic [2:0] v);
        exp_t e;
        drive_and_push(v);
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.step_ok !== e.step_ok) begin
            errors++;
            $display("FAIL step_ok v=%0d: got %b expected %b", v, bus.step_ok, e.step_ok);
        end
        checks++;
        if (bus.seq_err !== e.seq_err) begin
            errors++;
            $display("FAIL seq_err v=%0d: got %b expected %b", v, bus.seq_err, e.seq_err);
        end
        checks++;
        if (bus.led !== e.bar) begin
            errors++;
            $display("FAIL led v=%0d: got %b expected %b", v, bus.led, e.bar);
        end
        tick();
        checks++;
        if (bus.step_ok !== 1'b0 || bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width v=%0d: got ok=%b err=%b expected 0 0", v, bus.step_ok, bus.seq_err);
        end
        checks++;
        if (bus.err_cnt !== 8'(model_err)) begin
            errors++;
            $display("FAIL err_cnt v=%0d: got %0d expected %0d", v, bus.err_cnt, model_err);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.fading === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.fading !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: fading got %b expected 0 within 200 clks", bus.fading);
        end
    endtask

    // Called right after apply_count returns; fading has then been high for two samples.
    task automatic measure_fade(input string name, input logic chk_led, input logic [7:0] solid);
        int   n;
        logic led_bad;
        n       = 2;
        led_bad = 1'b0;
        while (bus.fading === 1'b1 && n < 100) begin
            if (chk_led && bus.led !== solid) led_bad = 1'b1;
            tick();
            if (bus.fading === 1'b1) n++;
        end
        checks++;
        if (n != FADE_LEN) begin
            errors++;
            $display("FAIL %s fade_len: got %0d expected %0d", name, n, FADE_LEN);
        end
        if (chk_led) begin
            checks++;
            if (led_bad) begin
                errors++;
                $display("FAIL %s led_solid: got varying led expected %b", name, solid);
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.count_in = 3'd0;
        bus.mode     = 1'b0;
        bus.err_clr  = 1'b0;
        model_prev   = 3'd0;
        model_mode   = 1'b0;
        model_err    = 0;
        repeat (3) tick();
        checks++;
        if (bus.led !== 8'h00 || bus.fading !== 1'b0 || bus.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got led=%b fading=%b err_cnt=%0d expected 0 0 0",
                     bus.led, bus.fading, bus.err_cnt);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.led !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_led: got %b expected 00000001", bus.led);
        end
        checks++;
        if (bus.step_ok !== 1'b0 || bus.seq_err !== 1'b0 || bus.fading !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ok=%b err=%b fading=%b expected 0 0 0",
                     bus.step_ok, bus.seq_err, bus.fading);
        end
    endtask

    task automatic test_count_sequence();
        logic [2:0] v;
        for (int k = 1; k <= 8; k++) begin
            v = 3'(k);
            wait_idle();
            apply_count(v);
            measure_fade("onehot_step", 1'b0, 8'h00);
            checks++;
            if (bus.led !== bar_model(v, 1'b0)) begin
                errors++;
                $display("FAIL onehot_after_fade v=%0d: got %b expected %b", v, bus.led, bar_model(v, 1'b0));
            end
        end
    endtask

    task automatic test_seq_err();
        logic seen_ghost;
        logic other_bad;
        int   err_pulses;
        int   ok_pulses;
        exp_t e;
        wait_idle();
        apply_count(3'd1);
        wait_idle();
        apply_count(3'd2);
        wait_idle();
        apply_count(3'd5);
        seen_ghost = 1'b0;
        other_bad  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.led[2] === 1'b1) seen_ghost = 1'b1;
            if ((bus.led & 8'hFB) !== 8'h20) other_bad = 1'b1;
            tick();
        end
        checks++;
        if (!seen_ghost || other_bad) begin
            errors++;
            $display("FAIL ghost_2: got seen=%b other_bad=%b expected 1 0", seen_ghost, other_bad);
        end
        wait_idle();
        checks++;
        if (bus.led !== 8'h20) begin
            errors++;
            $display("FAIL ghost_gone: got %b expected 00100000", bus.led);
        end
        // Back-to-back illegal changes every clock.
        err_pulses = 0;
        ok_pulses  = 0;
        for (int i = 0; i <= 300; i++) begin
            if (i < 300) drive_and_push((i % 2 == 0) ? 3'd3 : 3'd5);
            tick();
            if (bus.seq_err === 1'b1) err_pulses++;
            if (bus.step_ok === 1'b1) ok_pulses++;
            if (i >= 1) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.seq_err !== e.seq_err || bus.step_ok !== e.step_ok) begin
                    errors++;
                    $display("FAIL burst_pulse %0d: got ok=%b err=%b expected %b %b",
                             i, bus.step_ok, bus.seq_err, e.step_ok, e.seq_err);
                end
            end
        end
        tick();
        tick();
        checks++;
        if (err_pulses != 300 || ok_pulses != 0) begin
            errors++;
            $display("FAIL burst_count: got err=%0d ok=%0d expected 300 0", err_pulses, ok_pulses);
        end
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected 255", bus.err_cnt);
        end
    endtask

    task automatic test_err_clr();
        exp_t e;
        drive_and_push(3'd0);
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.seq_err !== e.seq_err) begin
            errors++;
            $display("FAIL clr_seq_err: got %b expected %b", bus.seq_err, e.seq_err);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        model_err   = 1;
        checks++;
        if (bus.err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_err: got %0d expected 1", bus.err_cnt);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        model_err   = 0;
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone: got %0d expected 0", bus.err_cnt);
        end
    endtask

    task automatic test_thermo();
        logic bad;
        wait_idle();
        bus.mode   = 1'b1;
        model_mode = 1'b1;
        apply_count(3'd3);
        wait_idle();
        apply_count(3'd4);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.led !== 8'b0001_1111) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || bus.fading !== 1'b1) begin
            errors++;
            $display("FAIL thermo_4: got led=%b fading=%b expected 00011111 1", bus.led, bus.fading);
        end
        apply_count(3'd5);
        measure_fade("thermo_restart", 1'b1, 8'b0011_1111);
    endtask

    task automatic test_reset_mid_fade();
        logic bad;
        wait_idle();
        bus.mode   = 1'b0;
        model_mode = 1'b0;
        apply_count(3'd6);
        repeat (11) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.led !== 8'h00 || bus.fading !== 1'b0 || bus.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_fade: got led=%b fading=%b err_cnt=%0d expected 0 0 0",
                     bus.led, bus.fading, bus.err_cnt);
        end
        bus.count_in = 3'd0;
        model_prev   = 3'd0;
        model_err    = 0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.led !== 8'h01 || bus.fading !== 1'b0 || bus.seq_err !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_residual_ghost: got led=%b fading=%b expected 00000001 0", bus.led, bus.fading);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_sequence();
        test_seq_err();
        test_err_clr();
        test_thermo();
        test_reset_mid_fade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
